display_hex_7seg: RTL and testbench

Downstream consumer of the 4-bit up/down hex counter. It takes the counter value `q` and the direction bit `dir`, and drives a 2-digit multiplexed 7-segment display:
- digit 0 shows the hex value;
- digit 1 shows 'U' (up) or 'd' (down).

When the counter sits at its limit (F counting up, 0 counting down), digit 0 blinks and a saturation flag is raised.

---
 rtl/disp_pkg.sv | 34 +++
 rtl/hex_7seg_decode.sv | 13 +
 rtl/display_hex_7seg.sv | 135 +++++++++++++
 tb/tb_display_hex_7seg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants and types for the 2-digit hex/direction 7-segment display.
package disp_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned AN_W    = 2;
    localparam int unsigned HEX_W   = 4;
    localparam int unsigned BLINK_W = 8;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
    localparam logic [SEG_W-1:0] SEG_U   = 7'h3E;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;

    localparam logic [AN_W-1:0] AN_DIG0 = 2'b10;
    localparam logic [AN_W-1:0] AN_DIG1 = 2'b01;
    localparam logic [AN_W-1:0] AN_NONE = 2'b11;

    // Segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
    localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        BLANK   = 1'b0,
        VISIBLE = 1'b1
    } blink_state_t;

    typedef struct packed {
        logic [SEG_W-1:0] seg;
        logic [AN_W-1:0]  an;
        logic             sat;
    } disp_out_t;

endpackage

// File: rtl/hex_7seg_decode.sv
// Combinational 4-bit hex value to 7-segment pattern lookup.
module hex_7seg_decode
    import disp_pkg::*;
(
    input  logic [HEX_W-1:0] value,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = HEX_SEG[value];
    end

endmodule

// File: rtl/display_hex_7seg.sv
// Two-digit multiplexed 7-segment driver for the hex up/down counter.
// Optional digit-0 blink on saturation is enabled by defining DISP_BLINK_EN.
module display_hex_7seg
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [HEX_W-1:0] q,
    input  logic             dir,
    output logic [SEG_W-1:0] seg,
    output logic [AN_W-1:0]  an,
    output logic             sat
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || SCAN_DIV > 65535 || BLINK_DIV < 1 || BLINK_DIV > 255) begin : g_bad_param
        $error("display_hex_7seg: SCAN_DIV or BLINK_DIV out of range");
    end

    logic [HEX_W-1:0]  q_r;
    logic              dir_r;
    logic [SCAN_W-1:0] scan_cnt;
    logic              digit_sel;
    logic              scan_tick_c;
    logic              sat_c;
    logic              digit0_vis_c;
    logic [SEG_W-1:0]  hex_seg_c;
    disp_out_t         out_c;

    // Stage 1: capture counter value and direction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_r   <= '0;
            dir_r <= 1'b0;
        end else begin
            q_r   <= q;
            dir_r <= dir;
        end
    end

    assign sat_c       = (!dir_r && (q_r == 4'hF)) || (dir_r && (q_r == 4'h0));
    assign scan_tick_c = (scan_cnt == SCAN_LAST);

    // Digit scan timing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_sel <= 1'b0;
        end else begin
            scan_cnt  <= scan_tick_c ? '0 : scan_cnt + SCAN_W'(1);
            digit_sel <= digit_sel ^ scan_tick_c;
        end
    end

`ifdef DISP_BLINK_EN
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    blink_state_t       blink_vis;
    blink_state_t       blink_vis_nx;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_cnt_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_vis <= VISIBLE;
            blink_cnt <= '0;
        end else begin
            blink_vis <= blink_vis_nx;
            blink_cnt <= blink_cnt_nx;
        end
    end

    // Blink phase only advances while saturated; any exit snaps back to VISIBLE
    always_comb begin
        blink_vis_nx = blink_vis;
        blink_cnt_nx = blink_cnt;
        if (!sat_c) begin
            blink_vis_nx = VISIBLE;
            blink_cnt_nx = '0;
        end else if (scan_tick_c) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nx = '0;
                case (blink_vis)
                    VISIBLE: blink_vis_nx = BLANK;
                    BLANK:   blink_vis_nx = VISIBLE;
                    default: blink_vis_nx = VISIBLE;
                endcase
            end else begin
                blink_cnt_nx = blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign digit0_vis_c = (blink_vis == VISIBLE);
`else
    assign digit0_vis_c = 1'b1;
`endif

    hex_7seg_decode u_decode (
        .value (q_r),
        .seg_c (hex_seg_c)
    );

    // Stage 2: select the active digit's pattern
    always_comb begin
        out_c.seg = SEG_OFF;
        out_c.an  = AN_NONE;
        out_c.sat = sat_c;
        if (!digit_sel) begin
            out_c.an  = AN_DIG0;
            out_c.seg = digit0_vis_c ? hex_seg_c : SEG_OFF;
        end else begin
            out_c.an  = AN_DIG1;
            out_c.seg = dir_r ? SEG_D : SEG_U;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= AN_NONE;
            sat <= 1'b0;
        end else begin
            seg <= out_c.seg;
            an  <= out_c.an;
            sat <= out_c.sat;
        end
    end

endmodule

// File: tb/tb_display_hex_7seg.sv
// Self-checking bench for display_hex_7seg: reset table, sweeps, blink corners, random traffic.
module tb_display_hex_7seg;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;
`ifdef DISP_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] q;
    logic       dir;
    logic [6:0] seg;
    logic [1:0] an;
    logic       sat;

    display_hex_7seg #(
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (q),
        .dir   (dir),
        .seg   (seg),
        .an    (an),
        .sat   (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tbl [16];

    // Reference model state: last sampled inputs, edges since reset, saturated scan ticks
    logic [3:0] m_q;
    logic       m_dir;
    int         m_edge;
    int         m_ticks;
    logic [6:0] e_seg;
    logic [1:0] e_an;
    logic       e_sat;

    typedef struct {
        logic       rst_n;
        logic [3:0] q;
        logic       dir;
        logic [6:0] seg;
        logic [1:0] an;
        logic       sat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected registered outputs for this edge, derived from the behavioural rules
    task automatic model_edge();
        bit   sat_now;
        int   digit;
        bit   vis;
        if (!rst_n) begin
            e_seg = 7'h00; e_an = 2'b11; e_sat = 1'b0;
            m_q = 4'h0; m_dir = 1'b0; m_edge = 0; m_ticks = 0;
        end else begin
            m_edge++;
            sat_now = (m_dir == 1'b0 && m_q == 4'hF) || (m_dir == 1'b1 && m_q == 4'h0);
            digit   = ((m_edge - 1) / SCAN_DIV) % 2;
            vis     = BLINK_EN ? (((m_ticks / BLINK_DIV) % 2) == 0) : 1'b1;
            if (digit == 0) begin
                e_an  = 2'b10;
                e_seg = vis ? hex_tbl[m_q] : 7'h00;
            end else begin
                e_an  = 2'b01;
                e_seg = m_dir ? 7'h5E : 7'h3E;
            end
            e_sat = sat_now;
            if (!sat_now) m_ticks = 0;
            else if ((m_edge % SCAN_DIV) == 0) m_ticks++;
            m_q   = q;
            m_dir = dir;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] qq, input logic d);
        @(negedge clk);
        rst_n = r; q = qq; dir = d;
        @(posedge clk);
        model_edge();
        #1;
        chk("seg", 32'(seg), 32'(e_seg));
        chk("an",  32'(an),  32'(e_an));
        chk("sat", 32'(sat), 32'(e_sat));
    endtask

    vec_t vecs [12];
    bit   saw_blank, saw_vis, bad_steady;
    int   hold;
    logic [3:0] rq;
    logic       rd;

    initial begin
        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst_n = 1'b0; q = 4'h0; dir = 1'b0;
        m_q = 4'h0; m_dir = 1'b0; m_edge = 0; m_ticks = 0;

        // Reset hold and first scan frames with q=5
        vecs = '{
            '{1'b0, 4'h5, 1'b0, 7'h00, 2'b11, 1'b0},
            '{1'b0, 4'h5, 1'b0, 7'h00, 2'b11, 1'b0},
            '{1'b0, 4'h5, 1'b0, 7'h00, 2'b11, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h3F, 2'b10, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h6D, 2'b10, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h6D, 2'b10, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h6D, 2'b10, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h3E, 2'b01, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h3E, 2'b01, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h3E, 2'b01, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h3E, 2'b01, 1'b0},
            '{1'b1, 4'h5, 1'b0, 7'h6D, 2'b10, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst_n, vecs[i].q, vecs[i].dir);
            chk("tbl_seg", 32'(seg), 32'(vecs[i].seg));
            chk("tbl_an",  32'(an),  32'(vecs[i].an));
            chk("tbl_sat", 32'(sat), 32'(vecs[i].sat));
        end

        // Up sweep through every hex value
        for (int v = 0; v < 16; v++)
            for (int k = 0; k < 8; k++) step(1'b1, 4'(v), 1'b0);

        // Saturated at F counting up: digit 0 must blink only when enabled
        saw_blank = 1'b0; saw_vis = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 4'hF, 1'b0);
            if (an == 2'b10 && seg == 7'h00) saw_blank = 1'b1;
            if (an == 2'b10 && seg == 7'h71) saw_vis = 1'b1;
            if (k >= 2) chk("sat_hold", 32'(sat), 32'd1);
        end
        chk("blink_seen", 32'(saw_blank), 32'(BLINK_EN));
        chk("vis_seen",   32'(saw_vis),   32'd1);

        // Advance into a blanked digit-0 window (bounded)
        for (int k = 0; k < 64; k++) begin
            if (e_an == 2'b10 && e_seg == 7'h00) break;
            step(1'b1, 4'hF, 1'b0);
        end

        // Direction flip while saturated: display steadies
        step(1'b1, 4'hF, 1'b1);
        step(1'b1, 4'hF, 1'b1);
        chk("sat_after_dir", 32'(sat), 32'd0);
        bad_steady = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 4'hF, 1'b1);
            if (an == 2'b10 && seg != 7'h71) bad_steady = 1'b1;
            if (an == 2'b01 && seg != 7'h5E) bad_steady = 1'b1;
        end
        chk("steady_after_dir", 32'(bad_steady), 32'd0);

        // Saturate at 0 counting down
        for (int k = 0; k < 24; k++) step(1'b1, 4'h0, 1'b1);
        chk("sat_down", 32'(sat), 32'd1);

        // Reset mid-blink, then restart at F/up
        for (int k = 0; k < 64; k++) begin
            if (e_an == 2'b10 && e_seg == 7'h00) break;
            step(1'b1, 4'h0, 1'b1);
        end
        step(1'b0, 4'hF, 1'b0);
        chk("rst_mid_seg", 32'(seg), 32'h00);
        chk("rst_mid_an",  32'(an),  32'h3);
        step(1'b1, 4'hF, 1'b0);
        chk("post_rst_first", 32'(seg), 32'h3F);
        step(1'b1, 4'hF, 1'b0);
        chk("post_rst_vis", 32'(seg), 32'h71);
        for (int k = 0; k < 40; k++) step(1'b1, 4'hF, 1'b0);

        // Random traffic biased toward the saturation values, with occasional resets
        for (int n = 0; n < 120; n++) begin
            case ($urandom_range(0, 3))
                0:       begin rq = 4'hF; rd = 1'b0; end
                1:       begin rq = 4'h0; rd = 1'b1; end
                default: begin rq = 4'($urandom_range(0, 15)); rd = 1'($urandom_range(0, 1)); end
            endcase
            hold = $urandom_range(1, 24);
            for (int k = 0; k < hold; k++)
                step(($urandom_range(0, 60) == 0) ? 1'b0 : 1'b1, rq, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
